// File: rtl/prescaled_mod_counter.sv
// prescaled_mod_counter
//   Modulo-MODULO up/down counter advanced by a clock-enable prescaler.
//   It supports a synchronous load, a start/restart strobe, a one-cycle
//   terminal-count pulse and an optional one-shot mode that stops after one
//   full span.
//
// Parameters
//   WIDTH     counter width in bits
//   MODULO    count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   PRESCALE  enabled clock cycles per count tick (>= 1)
//   ONESHOT   0 = free-running wrap, 1 = stop after one full span
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   en_i        clock enable for prescaler and counter
//   dir_i       1 = count up, 0 = count down (sampled on every tick)
//   load_i      synchronous load strobe (value clamped to MODULO-1)
//   load_val_i  load value
//   start_i     (re)start strobe
//   count_o     current count, registered
//   tc_o        one-cycle terminal-count pulse, registered
//   busy_o      high while the FSM is in RUN
module prescaled_mod_counter #(
  parameter int WIDTH    = 6,
  parameter int MODULO   = 10,
  parameter int PRESCALE = 1,
  parameter int ONESHOT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]  PRE_TOP = PW'(PRESCALE - 1);

  generate
    if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
      $error("prescaled_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("prescaled_mod_counter: PRESCALE must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A free-running counter comes out of reset already counting; a one-shot
  // waits for start_i.
  localparam state_t RST_STATE = (ONESHOT != 0) ? IDLE : RUN;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic             tc_q,    tc_d;
  logic             tick;

  assign tick = en_i && (state_q == RUN) && (pre_q == PRE_TOP);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;

    if (load_i) begin
      // Load wins over start and tick; a coincident start still enters RUN.
      count_d = (load_val_i > TOP) ? TOP : load_val_i;
      pre_d   = '0;
      if (start_i) begin
        state_d = RUN;
      end
    end else if (start_i) begin
      state_d = RUN;
      pre_d   = '0;
      count_d = dir_i ? '0 : TOP;
    end else if (en_i && (state_q == RUN)) begin
      if (tick) begin
        pre_d = '0;
        if (dir_i) begin
          if (count_q == TOP) begin
            tc_d = 1'b1;
            // One-shot holds the terminal value instead of wrapping.
            if (ONESHOT != 0) begin
              state_d = DONE;
            end else begin
              count_d = '0;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            tc_d = 1'b1;
            if (ONESHOT != 0) begin
              state_d = DONE;
            end else begin
              count_d = TOP;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign busy_o  = (state_q == RUN);

endmodule
